// File: rtl/bram_ctrl.sv
// bram_ctrl: valid/ready request front end for a 1-cycle registered-read BRAM.
// It takes one request at a time and checks it against the BRAM address window.
// It then drives the BRAM write/read ports and waits out the read latency.
// Completion is reported with a single-cycle mem_ready pulse.
module bram_ctrl #(
  parameter int          BRAM_DEPTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  output logic                  mem_error,
  output logic                  bram_wen,
  output logic [BRAM_DEPTH-1:0] bram_waddr,
  output logic [BRAM_DEPTH-1:0] bram_raddr,
  output logic [31:0]           bram_wdata,
  output logic [3:0]            bram_wstrb,
  input  logic [31:0]           bram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_ready_q, mem_ready_d;
  logic        mem_error_q, mem_error_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [3:0]  issue_strb_q, issue_strb_d;
  logic        addr_err;
  logic        unused_addr_bits;

  // The request is out of range when any bit above the word index differs from the window base.
  assign addr_err = (mem_addr[31:BRAM_DEPTH+2] != BASE_ADDR[31:BRAM_DEPTH+2]);

  // Only the word-index bits of the captured address reach the BRAM.
  assign unused_addr_bits = ^{addr_q[31:BRAM_DEPTH+2], addr_q[1:0]};

  // The BRAM ports always mirror the captured request, and the strobes are live only in ISSUE.
  // Reset gates the write enable directly, so an in-flight write is killed within the same cycle.
  assign bram_waddr = addr_q[BRAM_DEPTH+1:2];
  assign bram_raddr = addr_q[BRAM_DEPTH+1:2];
  assign bram_wdata = wdata_q;
  assign bram_wstrb = issue_strb_q;
  assign bram_wen   = (issue_strb_q != 4'd0) && !rst;

  assign mem_ready = mem_ready_q;
  assign mem_error = mem_error_q;
  assign mem_rdata = mem_rdata_q;

  // Next-state and next-output logic.
  // Response outputs are computed one cycle early so that they come straight from flops in DONE.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    mem_ready_d  = 1'b0;
    mem_error_d  = 1'b0;
    mem_rdata_d  = 32'd0;
    issue_strb_d = 4'd0;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          err_d   = addr_err;
          if (addr_err) begin
            state_d     = DONE;
            mem_ready_d = 1'b1;
            mem_error_d = 1'b1;
          end else begin
            state_d      = ISSUE;
            issue_strb_d = mem_wstrb;
          end
        end
      end
      ISSUE: begin
        if (wstrb_q != 4'd0) begin
          state_d     = DONE;
          mem_ready_d = 1'b1;
          mem_error_d = err_q;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        rdata_d     = bram_rdata;
        mem_rdata_d = bram_rdata;
        mem_ready_d = 1'b1;
        mem_error_d = err_q;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      err_q        <= 1'b0;
      rdata_q      <= 32'd0;
      mem_ready_q  <= 1'b0;
      mem_error_q  <= 1'b0;
      mem_rdata_q  <= 32'd0;
      issue_strb_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      mem_ready_q  <= mem_ready_d;
      mem_error_q  <= mem_error_d;
      mem_rdata_q  <= mem_rdata_d;
      issue_strb_q <= issue_strb_d;
    end
  end

endmodule

// File: tb/tb_bram_ctrl.sv
// tb_bram_ctrl: directed scoreboard bench for bram_ctrl with a behavioural 1-cycle BRAM.
module tb_bram_ctrl;

  localparam int          DEPTH = 10;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             mem_valid = 1'b0;
  logic [31:0]      mem_addr = 32'd0;
  logic [31:0]      mem_wdata = 32'd0;
  logic [3:0]       mem_wstrb = 4'd0;
  logic             mem_ready;
  logic [31:0]      mem_rdata;
  logic             mem_error;
  logic             bram_wen;
  logic [DEPTH-1:0] bram_waddr;
  logic [DEPTH-1:0] bram_raddr;
  logic [31:0]      bram_wdata;
  logic [3:0]       bram_wstrb;
  logic [31:0]      bram_rdata;

  logic [31:0]      bram_mem [0:(1<<DEPTH)-1];

  exp_t             sb_q[$];
  int               checks = 0;
  int               errors = 0;
  int               wen_count = 0;
  int               ready_count = 0;
  int               expected_ready = 0;
  logic [31:0]      last_waddr = 32'd0;
  logic [31:0]      issue_raddr = 32'd0;

  bram_ctrl #(.BRAM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .mem_error  (mem_error),
    .bram_wen   (bram_wen),
    .bram_waddr (bram_waddr),
    .bram_raddr (bram_raddr),
    .bram_wdata (bram_wdata),
    .bram_wstrb (bram_wstrb),
    .bram_rdata (bram_rdata)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Behavioural BRAM: byte-strobed write and registered read.
  always @(posedge clk) begin
    if (bram_wen) begin
      for (int b = 0; b < 4; b++) begin
        if (bram_wstrb[b]) bram_mem[bram_waddr][8*b +: 8] <= bram_wdata[8*b +: 8];
      end
    end
    bram_rdata <= bram_mem[bram_raddr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Write-enable activity monitor: counts BRAM write cycles and remembers the last write index.
  always @(negedge clk) begin
    if (bram_wen === 1'b1) begin
      wen_count++;
      last_waddr = 32'(bram_waddr);
    end
  end

  // Response monitor: pops the scoreboard on every mem_ready; response lines must be quiet otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (mem_ready === 1'b1) begin
      ready_count++;
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_ready", 32'(mem_ready), 32'd0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("rdata", mem_rdata, e.rdata);
        checkOutput("error", 32'(mem_error), 32'(e.err));
      end
    end else begin
      checkOutput("idle_resp", {31'd0, mem_error} | mem_rdata, 32'd0);
    end
  end

  task automatic checkResetOutputs();
    checkOutput("rst_ready", 32'(mem_ready), 32'd0);
    checkOutput("rst_error", 32'(mem_error), 32'd0);
    checkOutput("rst_rdata", mem_rdata, 32'd0);
    checkOutput("rst_wen", 32'(bram_wen), 32'd0);
    checkOutput("rst_wstrb", 32'(bram_wstrb), 32'd0);
    checkOutput("rst_waddr", 32'(bram_waddr), 32'd0);
    checkOutput("rst_raddr", 32'(bram_raddr), 32'd0);
    checkOutput("rst_wdata", bram_wdata, 32'd0);
  endtask

  // Wait (bounded) for mem_ready and return the number of cycles after the starting point.
  // Once the request has been captured, the request inputs are scrambled to prove they are no longer used.
  task automatic waitReady(input int issue_at, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      if (lat == issue_at) issue_raddr = 32'(bram_raddr);
      if (mem_ready === 1'b1) begin
        seen = 1'b1;
      end else if (lat >= issue_at) begin
        mem_addr  = mem_addr ^ 32'h0000_0FF0;
        mem_wdata = ~mem_wdata;
        mem_wstrb = ~mem_wstrb;
      end
    end
    if (!seen) begin
      $display("[TB] FAIL ready_timeout: got none expected mem_ready within 12 cycles");
      errors++;
      checks++;
      sb_q.delete();
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                               input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                               input int exp_idx);
    int lat;
    int wen0;
    @(negedge clk);
    rst       = 1'b0;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    expected_ready++;
    wen0 = wen_count;
    waitReady(1, lat);
    mem_valid = 1'b0;
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("wen_cycles", 32'(wen_count - wen0), (strb != 4'd0 && !exp_err) ? 32'd1 : 32'd0);
    if (!exp_err) checkOutput("raddr", issue_raddr, 32'(exp_idx));
    if (strb != 4'd0 && !exp_err) checkOutput("waddr", last_waddr, 32'(exp_idx));
  endtask

  // Directed sequence.
  initial begin
    int lat;
    int wen0;

    repeat (3) @(negedge clk);
    checkResetOutputs();

    applyStimulus(BASE + 32'h0,    32'h1111_1111, 4'hF, 32'h0, 1'b0, 2, 0);
    applyStimulus(BASE + 32'h8,    32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 2, 2);
    applyStimulus(BASE + 32'h8,    32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 3, 2);
    applyStimulus(BASE + 32'h8,    32'h0000_AA00, 4'b0010, 32'h0, 1'b0, 2, 2);
    applyStimulus(BASE + 32'h8,    32'h0,         4'h0, 32'hDEAD_AAEF, 1'b0, 3, 2);
    applyStimulus(BASE + 32'hFFC,  32'h0BAD_C0DE, 4'hF, 32'h0, 1'b0, 2, 1023);
    applyStimulus(BASE + 32'hFFC,  32'h0,         4'h0, 32'h0BAD_C0DE, 1'b0, 3, 1023);
    applyStimulus(BASE + 32'h1000, 32'h0,         4'h0, 32'h0, 1'b1, 1, 0);
    applyStimulus(BASE + 32'h1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1, 0);
    applyStimulus(BASE - 32'h4,    32'h0,         4'h0, 32'h0, 1'b1, 1, 0);
    applyStimulus(BASE + 32'h0,    32'h0,         4'h0, 32'h1111_1111, 1'b0, 3, 0);

    // Back-to-back: valid stays high and the read of the same word follows the write immediately.
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'hC;
    mem_wdata = 32'hCAFE_F00D;
    mem_wstrb = 4'hF;
    sb_q.push_back('{rdata: 32'h0, err: 1'b0});
    expected_ready++;
    waitReady(1, lat);
    checkOutput("b2b_write_latency", 32'(lat), 32'd2);
    mem_addr  = BASE + 32'hC;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    sb_q.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
    expected_ready++;
    waitReady(2, lat);
    mem_valid = 1'b0;
    checkOutput("b2b_read_latency", 32'(lat), 32'd4);
    checkOutput("b2b_raddr", issue_raddr, 32'd3);

    // Reset during the ISSUE cycle of a write: the write and its response must vanish.
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = BASE;
    mem_wdata = 32'h2222_2222;
    mem_wstrb = 4'hF;
    wen0      = wen_count;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    mem_valid = 1'b0;
    @(negedge clk);
    checkOutput("wen_under_rst", 32'(bram_wen), 32'd0);
    @(negedge clk);
    checkResetOutputs();
    repeat (2) @(negedge clk);
    checkOutput("rst_wen_cycles", 32'(wen_count - wen0), 32'd0);
    applyStimulus(BASE + 32'h0,    32'h0,         4'h0, 32'h1111_1111, 1'b0, 3, 0);

    repeat (3) @(negedge clk);
    checkOutput("ready_pulses", 32'(ready_count), 32'(expected_ready));
    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
